// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
// ------------
// UART transmit controller. Accepts one byte on a valid/ready handshake and
// serialises it as a start bit, DATA_BITS data bits (LSB first), an optional
// parity bit and STOP_BITS stop bits. The external baud generator is enabled
// for the whole frame and cleared once at frame start. The line advances one
// bit per baud_tick.
//
// Parameters
//   DATA_BITS  : data bits per frame, 5..8
//   PARITY_EN  : 1 inserts a parity bit after the data bits
//   PARITY_ODD : 1 selects odd parity, 0 selects even parity
//   STOP_BITS  : 1 or 2 stop bits
//
// Ports
//   clk       in   system clock, rising edge
//   reset_n   in   synchronous active-low reset
//   tx_data   in   byte to send, sampled on the accept cycle only
//   tx_valid  in   source has a byte
//   tx_ready  out  controller can accept (IDLE only)
//   baud_tick in   one-cycle bit-period tick from the baud generator
//   baud_en   out  baud generator count enable (every non-IDLE state)
//   baud_clr  out  one-cycle baud generator clear at frame start
//   tx        out  serial line, idle high
//   busy      out  frame in progress
//   tx_done   out  one-cycle pulse after the final stop bit
module uart_tx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 baud_tick,
    output logic                 baud_en,
    output logic                 baud_clr,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic       ODD_SEL   = (PARITY_ODD != 0);

    logic [2:0]           state_q,  state_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic [2:0]           idx_q,    idx_d;
    logic                 stop_q,   stop_d;
    logic                 parity_q, parity_d;
    logic                 tx_q,     tx_d;
    logic                 clr_q,    clr_d;
    logic                 done_q,   done_d;

    // Next-state logic. The line value is computed one state ahead so that
    // tx is a plain register and only moves on accept, tick or reset.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        stop_d   = stop_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        clr_d    = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (tx_valid) begin
                    shift_d  = tx_data;
                    parity_d = (^tx_data) ^ ODD_SEL;
                    idx_d    = 3'd0;
                    stop_d   = 1'b0;
                    tx_d     = 1'b0;
                    clr_d    = 1'b1;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        // Index is held at its last value rather than wrapping.
                        if (PARITY_EN != 0) begin
                            tx_d    = parity_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            stop_d  = 1'b0;
                            state_d = S_STOP;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_d[0];
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (baud_tick) begin
                    if (stop_q == LAST_STOP) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers. Reset wins over any coincident tick or handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            idx_q    <= 3'd0;
            stop_q   <= 1'b0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            clr_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            stop_q   <= stop_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            clr_q    <= clr_d;
            done_q   <= done_d;
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign baud_en  = (state_q != S_IDLE);
    assign baud_clr = clr_q;
    assign tx       = tx_q;
    assign tx_done  = done_q;

endmodule
